turbo_iter_ctrl: RTL

//  Iteration controller that time-shares one Siso (max-log-MAP, 7 steps, 13-bit LLR) between

---
 rtl/turbo_iter_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/turbo_iter_ctrl.sv
`default_nettype none
// turbo_iter_ctrl: time-shares one max-log-MAP Siso between the two constituent decoders,
// running N_ITER iterations per frame with a 7-point interleaver and a finish watchdog.
module turbo_iter_ctrl #(
  parameter int          LLR_W   = 13,
  parameter int          N_ITER  = 4,
  parameter logic [20:0] PI      = {3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd5, 3'd2},
  parameter int          TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [27:0]        sys_i,
  input  logic [27:0]        par1_i,
  input  logic [27:0]        par2_i,
  output logic               siso_read_en_o,
  output logic [27:0]        siso_sys_o,
  output logic [27:0]        siso_enc_o,
  output logic [7*LLR_W-1:0] siso_ext_o,
  input  logic [7*LLR_W-1:0] siso_data_i,
  input  logic               siso_finish_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [7*LLR_W-1:0] llr_o,
  output logic [6:0]         bits_o,
  output logic [3:0]         iter_o,
  output logic               timeout_o
);

  localparam int BUS_W = 7 * LLR_W;
  localparam int EXT_W = LLR_W + 3;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (LLR_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    WAIT1 = 3'd2,
    EXT1  = 3'd3,
    LOAD2 = 3'd4,
    WAIT2 = 3'd5,
    EXT2  = 3'd6,
    OUT   = 3'd7
  } state_t;

  function automatic int pi_at(input int k);
    return int'(PI[20 - 3 * k -: 3]);
  endfunction

  // Extrinsic = (L - 2a - 2s) / 2 with floor rounding, clipped to the LLR range.
  function automatic logic [LLR_W-1:0] ext_calc(input logic [LLR_W-1:0] l,
                                                input logic [LLR_W-1:0] a,
                                                input logic [3:0]       s);
    logic signed [EXT_W-1:0] d;
    d = $signed({{3{l[LLR_W-1]}}, l})
      - $signed({{2{a[LLR_W-1]}}, a, 1'b0})
      - $signed({{(EXT_W - 5){s[3]}}, s, 1'b0});
    d = d >>> 1;
    if (d > SAT_MAX)      return SAT_MAX[LLR_W-1:0];
    else if (d < SAT_MIN) return SAT_MIN[LLR_W-1:0];
    else                  return d[LLR_W-1:0];
  endfunction

  state_t             state;
  logic [27:0]        sys_q;
  logic [27:0]        par1_q;
  logic [27:0]        par2_q;
  logic [LLR_W-1:0]   store [7];
  logic [LLR_W-1:0]   llr_q [7];
  logic [BUS_W-1:0]   data_q;
  logic [CNT_W-1:0]   wd_cnt;
  logic [3:0]         iter_q;
  logic               timeout_q;
  logic               read_en_q;
  logic               out_valid_q;

  logic               phase2;
  logic [27:0]        sys_bus;
  logic [BUS_W-1:0]   store_bus;
  logic [BUS_W-1:0]   llr_bus;
  logic [6:0]         bits;
  logic [LLR_W-1:0]   ext_new [7];

  always_comb begin
    phase2    = (state == LOAD2) || (state == WAIT2) || (state == EXT2);
    sys_bus   = sys_q;
    store_bus = '0;
    llr_bus   = '0;
    bits      = '0;
    for (int k = 0; k < 7; k++) begin
      if (phase2) sys_bus[27 - 4 * k -: 4] = sys_q[27 - 4 * pi_at(k) -: 4];
      store_bus[BUS_W - 1 - LLR_W * k -: LLR_W] = store[k];
      llr_bus[BUS_W - 1 - LLR_W * k -: LLR_W]   = llr_q[k];
      bits[6 - k] = ~llr_q[k][LLR_W-1] & (|llr_q[k]);
    end
    // a and s are taken from the buses still being presented to the Siso.
    for (int k = 0; k < 7; k++) begin
      ext_new[k] = ext_calc(data_q[BUS_W - 1 - LLR_W * k -: LLR_W], store[k],
                            sys_bus[27 - 4 * k -: 4]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      sys_q       <= '0;
      par1_q      <= '0;
      par2_q      <= '0;
      data_q      <= '0;
      wd_cnt      <= '0;
      iter_q      <= '0;
      timeout_q   <= 1'b0;
      read_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 7; k++) begin
        store[k] <= '0;
        llr_q[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid_i) begin
            sys_q     <= sys_i;
            par1_q    <= par1_i;
            par2_q    <= par2_i;
            iter_q    <= '0;
            timeout_q <= 1'b0;
            read_en_q <= 1'b1;
            state     <= LOAD1;
            for (int k = 0; k < 7; k++) store[k] <= '0;
          end
        end
        LOAD1, LOAD2: begin
          read_en_q <= 1'b0;
          wd_cnt    <= '0;
          state     <= (state == LOAD1) ? WAIT1 : WAIT2;
        end
        WAIT1, WAIT2: begin
          if (siso_finish_i) begin
            data_q <= siso_data_i;
            state  <= (state == WAIT1) ? EXT1 : EXT2;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        EXT1: begin
          for (int k = 0; k < 7; k++) store[k] <= ext_new[pi_at(k)];
          read_en_q <= 1'b1;
          state     <= LOAD2;
        end
        EXT2: begin
          for (int k = 0; k < 7; k++) begin
            store[pi_at(k)] <= ext_new[k];
            llr_q[pi_at(k)] <= data_q[BUS_W - 1 - LLR_W * k -: LLR_W];
          end
          iter_q <= iter_q + 4'd1;
          if (({1'b0, iter_q} + 5'd1) < 5'(N_ITER)) begin
            read_en_q <= 1'b1;
            state     <= LOAD1;
          end else begin
            out_valid_q <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready_o     = (state == IDLE);
  assign siso_read_en_o = read_en_q;
  assign siso_sys_o     = sys_bus;
  assign siso_enc_o     = phase2 ? par2_q : par1_q;
  assign siso_ext_o     = store_bus;
  assign out_valid_o    = out_valid_q;
  assign llr_o          = llr_bus;
  assign bits_o         = bits;
  assign iter_o         = iter_q;
  assign timeout_o      = timeout_q;

endmodule
`default_nettype wire
